// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_if
// Description : Bundles the EX/MEM inputs and the branch-resolution / MEM/WB
//               outputs of the memory stage.
//               master : the pipeline side that drives ex_mem_* and consumes
//                        pcsrc, branch_target, flush, mem_wb_* and misalign.
//               slave  : the memory stage itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_stage_if;
    // EX/MEM pipeline register contents
    logic [63:0] ex_mem_adderout;
    logic [63:0] ex_mem_result;
    logic [3:0]  ex_mem_funct;
    logic [63:0] ex_mem_readdata1;
    logic [63:0] ex_mem_writedata;
    logic [4:0]  ex_mem_rd;
    logic        ex_mem_branch;
    logic        ex_mem_memread;
    logic        ex_mem_memtoreg;
    logic        ex_mem_memwrite;
    logic        ex_mem_regwrite;

    // Branch resolution (combinational)
    logic        pcsrc;
    logic [63:0] branch_target;
    logic        flush;

    // MEM/WB pipeline register contents
    logic [63:0] mem_wb_readdata;
    logic [63:0] mem_wb_result;
    logic [4:0]  mem_wb_rd;
    logic        mem_wb_memtoreg;
    logic        mem_wb_regwrite;
    logic        misalign;

    modport master (
        output ex_mem_adderout, ex_mem_result, ex_mem_funct, ex_mem_readdata1,
               ex_mem_writedata, ex_mem_rd, ex_mem_branch, ex_mem_memread,
               ex_mem_memtoreg, ex_mem_memwrite, ex_mem_regwrite,
        input  pcsrc, branch_target, flush, mem_wb_readdata, mem_wb_result,
               mem_wb_rd, mem_wb_memtoreg, mem_wb_regwrite, misalign
    );

    modport slave (
        input  ex_mem_adderout, ex_mem_result, ex_mem_funct, ex_mem_readdata1,
               ex_mem_writedata, ex_mem_rd, ex_mem_branch, ex_mem_memread,
               ex_mem_memtoreg, ex_mem_memwrite, ex_mem_regwrite,
        output pcsrc, branch_target, flush, mem_wb_readdata, mem_wb_result,
               mem_wb_rd, mem_wb_memtoreg, mem_wb_regwrite, misalign
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : Pipeline MEM stage: byte-addressed little-endian data memory
//               (DEPTH_BYTES bytes, addresses wrap), sign/zero-extending
//               loads, sized stores, branch resolution, and the MEM/WB
//               pipeline register.
// Ports       : clk   - clock, all state updates on its rising edge
//               reset - synchronous active-high reset; clears memory and MEM/WB
//               bus   - mem_stage_if.slave: ex_mem_* in; pcsrc, branch_target,
//                       flush, mem_wb_*, misalign out
// Config      : MEM_MISALIGN_CHECK_EN - when defined, misaligned half/word/
//               double accesses are suppressed and flagged on misalign.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int DEPTH_BYTES = 256
) (
    input  wire logic  clk,
    input  wire logic  reset,
    mem_stage_if.slave bus
);

    localparam int c_ADDR_W = $clog2(DEPTH_BYTES);

    logic [7:0]          r_mem [DEPTH_BYTES];

    logic [c_ADDR_W-1:0] w_addr;
    logic [2:0]          w_f3;
    logic [3:0]          w_nbytes;
    logic [63:0]         w_raw;
    logic [63:0]         w_load;
    logic                w_misalign;
    logic                w_store;
    logic                w_cond;
    logic                w_pcsrc;

    logic [63:0]         r_readdata;
    logic [63:0]         r_result;
    logic [4:0]          r_rd;
    logic                r_memtoreg;
    logic                r_regwrite;
    logic                r_misalign;

    // Upper address bits are discarded by the modulo addressing and funct bit 3
    // carries no meaning for this stage.
    logic                w_unused;
    assign w_unused = &{1'b0, bus.ex_mem_funct[3], bus.ex_mem_result[63:c_ADDR_W]};

    assign w_addr   = bus.ex_mem_result[c_ADDR_W-1:0];
    assign w_f3     = bus.ex_mem_funct[2:0];
    // Access size in bytes: funct3[1:0] encodes log2(size) for loads and stores.
    assign w_nbytes = 4'd1 << w_f3[1:0];

    // Gather eight consecutive bytes starting at the address; the index is
    // c_ADDR_W bits wide, so running off the top wraps back to byte 0.
    always_comb begin
        w_raw = '0;
        for (int k = 0; k < 8; k++) begin
            w_raw[8*k +: 8] = r_mem[w_addr + c_ADDR_W'(k)];
        end
    end

    always_comb begin
        w_load = '0;
        case (w_f3)
            3'b000:  w_load = {{56{w_raw[7]}},  w_raw[7:0]};
            3'b001:  w_load = {{48{w_raw[15]}}, w_raw[15:0]};
            3'b010:  w_load = {{32{w_raw[31]}}, w_raw[31:0]};
            3'b011:  w_load = w_raw;
            3'b100:  w_load = {56'd0, w_raw[7:0]};
            3'b101:  w_load = {48'd0, w_raw[15:0]};
            3'b110:  w_load = {32'd0, w_raw[31:0]};
            default: w_load = '0;
        endcase
    end

`ifdef MEM_MISALIGN_CHECK_EN
    // Only real accesses can be misaligned: loads other than funct3=111 and
    // stores with funct3[2]=0. Byte accesses give a zero mask and never trip.
    always_comb begin
        w_misalign = 1'b0;
        if ((bus.ex_mem_memread && (w_f3 != 3'b111)) ||
            (bus.ex_mem_memwrite && !w_f3[2])) begin
            w_misalign = (bus.ex_mem_result[2:0] & (w_nbytes[2:0] - 3'd1)) != 3'd0;
        end
    end
`else
    assign w_misalign = 1'b0;
`endif

    assign w_store = bus.ex_mem_memwrite && !w_f3[2] && !w_misalign;

    // Branch condition: A = rs1, B = rs2.
    always_comb begin
        w_cond = 1'b0;
        case (w_f3)
            3'b000:  w_cond = (bus.ex_mem_readdata1 == bus.ex_mem_writedata);
            3'b001:  w_cond = (bus.ex_mem_readdata1 != bus.ex_mem_writedata);
            3'b100:  w_cond = ($signed(bus.ex_mem_readdata1) <  $signed(bus.ex_mem_writedata));
            3'b101:  w_cond = ($signed(bus.ex_mem_readdata1) >= $signed(bus.ex_mem_writedata));
            3'b110:  w_cond = (bus.ex_mem_readdata1 <  bus.ex_mem_writedata);
            3'b111:  w_cond = (bus.ex_mem_readdata1 >= bus.ex_mem_writedata);
            default: w_cond = 1'b0;
        endcase
    end

    assign w_pcsrc           = !reset && bus.ex_mem_branch && w_cond;
    assign bus.pcsrc         = w_pcsrc;
    assign bus.flush         = w_pcsrc;
    assign bus.branch_target = bus.ex_mem_adderout;

    // Memory and MEM/WB register. The load value comes from the pre-edge
    // memory contents, so a simultaneous read and write to the same location
    // returns the old data.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_BYTES; i++) begin
                r_mem[i] <= 8'h00;
            end
            r_readdata <= '0;
            r_result   <= '0;
            r_rd       <= '0;
            r_memtoreg <= 1'b0;
            r_regwrite <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            if (w_store) begin
                for (int k = 0; k < 8; k++) begin
                    if (4'(k) < w_nbytes) begin
                        r_mem[w_addr + c_ADDR_W'(k)] <= bus.ex_mem_writedata[8*k +: 8];
                    end
                end
            end
            r_readdata <= (bus.ex_mem_memread && !w_misalign) ? w_load : 64'd0;
            r_result   <= bus.ex_mem_result;
            r_rd       <= bus.ex_mem_rd;
            r_memtoreg <= bus.ex_mem_memtoreg;
            r_regwrite <= bus.ex_mem_regwrite && !w_misalign;
            r_misalign <= w_misalign;
        end
    end

    assign bus.mem_wb_readdata = r_readdata;
    assign bus.mem_wb_result   = r_result;
    assign bus.mem_wb_rd       = r_rd;
    assign bus.mem_wb_memtoreg = r_memtoreg;
    assign bus.mem_wb_regwrite = r_regwrite;
    assign bus.misalign        = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Self-checking bench for mem_stage. Directed scenarios plus
//               randomized traffic compared against a byte-array memory model
//               and arithmetic branch/load rules. Honours
//               MEM_MISALIGN_CHECK_EN in its model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    localparam int c_DEPTH = 256;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    mem_stage_if bus ();

    mem_stage #(.DEPTH_BYTES(c_DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mdl_mem [c_DEPTH];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int mdl_addr();
        return int'(bus.ex_mem_result % 64'(c_DEPTH));
    endfunction

    function automatic logic [63:0] mdl_load(input int addr, input logic [2:0] f3);
        logic [63:0] raw;
        raw = 64'd0;
        for (int k = 0; k < 8; k++) begin
            raw = raw | (64'(mdl_mem[(addr + k) % c_DEPTH]) << (8 * k));
        end
        case (f3)
            3'd0:    return longint'($signed(raw[7:0]));
            3'd1:    return longint'($signed(raw[15:0]));
            3'd2:    return longint'($signed(raw[31:0]));
            3'd3:    return raw;
            3'd4:    return raw % 64'd256;
            3'd5:    return raw % 64'd65536;
            3'd6:    return raw % 64'h1_0000_0000;
            default: return 64'd0;
        endcase
    endfunction

    function automatic bit mdl_mis();
`ifdef MEM_MISALIGN_CHECK_EN
        int sz;
        logic [2:0] f3;
        f3 = bus.ex_mem_funct[2:0];
        sz = 1 << f3[1:0];
        if ((bus.ex_mem_memread && f3 != 3'd7) || (bus.ex_mem_memwrite && f3 < 3'd4))
            return (mdl_addr() % sz) != 0;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit mdl_taken();
        longint          sa, sb;
        longint unsigned ua, ub;
        sa = bus.ex_mem_readdata1;  sb = bus.ex_mem_writedata;
        ua = bus.ex_mem_readdata1;  ub = bus.ex_mem_writedata;
        if (reset || !bus.ex_mem_branch) return 1'b0;
        case (bus.ex_mem_funct[2:0])
            3'd0:    return ua == ub;
            3'd1:    return ua != ub;
            3'd4:    return sa < sb;
            3'd5:    return sa >= sb;
            3'd6:    return ua < ub;
            3'd7:    return ua >= ub;
            default: return 1'b0;
        endcase
    endfunction

    // One clock: inputs are already set; check branch outputs, clock, check
    // MEM/WB, then apply the store to the model.
    task automatic do_cycle();
        logic [63:0] e_rdata, e_res;
        logic [4:0]  e_rd;
        logic        e_mtr, e_rw, e_mis, e_pc;
        int          addr;
        int          nb;
        #1;
        e_pc = mdl_taken();
        check("pcsrc", 64'(bus.pcsrc), 64'(e_pc));
        check("flush", 64'(bus.flush), 64'(e_pc));
        check("branch_target", bus.branch_target, bus.ex_mem_adderout);
        addr  = mdl_addr();
        e_mis = mdl_mis();
        if (reset) begin
            e_rdata = 0; e_res = 0; e_rd = 0; e_mtr = 0; e_rw = 0; e_mis = 0;
        end else begin
            e_rdata = (bus.ex_mem_memread && !e_mis) ? mdl_load(addr, bus.ex_mem_funct[2:0]) : 64'd0;
            e_res   = bus.ex_mem_result;
            e_rd    = bus.ex_mem_rd;
            e_mtr   = bus.ex_mem_memtoreg;
            e_rw    = bus.ex_mem_regwrite && !e_mis;
        end
        @(posedge clk);
        #1;
        check("mem_wb_readdata", bus.mem_wb_readdata, e_rdata);
        check("mem_wb_result", bus.mem_wb_result, e_res);
        check("mem_wb_rd", 64'(bus.mem_wb_rd), 64'(e_rd));
        check("mem_wb_memtoreg", 64'(bus.mem_wb_memtoreg), 64'(e_mtr));
        check("mem_wb_regwrite", 64'(bus.mem_wb_regwrite), 64'(e_rw));
        check("misalign", 64'(bus.misalign), 64'(e_mis));
        if (reset) begin
            for (int i = 0; i < c_DEPTH; i++) mdl_mem[i] = 8'h00;
        end else if (bus.ex_mem_memwrite && bus.ex_mem_funct[2:0] < 3'd4 && !e_mis) begin
            nb = 1 << bus.ex_mem_funct[1:0];
            for (int k = 0; k < nb; k++)
                mdl_mem[(addr + k) % c_DEPTH] = bus.ex_mem_writedata[8*k +: 8];
        end
    endtask

    task automatic set_op(input logic br, input logic mr, input logic mw, input logic rw,
                          input logic [3:0] f, input logic [63:0] res,
                          input logic [63:0] a, input logic [63:0] b);
        bus.ex_mem_branch    = br;
        bus.ex_mem_memread   = mr;
        bus.ex_mem_memwrite  = mw;
        bus.ex_mem_regwrite  = rw;
        bus.ex_mem_memtoreg  = mr;
        bus.ex_mem_funct     = f;
        bus.ex_mem_result    = res;
        bus.ex_mem_readdata1 = a;
        bus.ex_mem_writedata = b;
        bus.ex_mem_rd        = 5'($urandom);
        bus.ex_mem_adderout  = {$urandom, $urandom};
    endtask

    initial begin
        logic [63:0] r;
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < c_DEPTH; i++) mdl_mem[i] = 8'h00;

        // Reset with a true branch and a store pending: pcsrc forced low,
        // MEM/WB cleared, store discarded.
        reset = 1'b1;
        set_op(1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 64'h40, 64'h5, 64'h5);
        do_cycle();
        do_cycle();
        reset = 1'b0;
        set_op(1'b0, 1'b1, 1'b0, 1'b1, 4'b0011, 64'h40, 64'h0, 64'h0);
        do_cycle();
        check("store_under_reset", bus.mem_wb_readdata, 64'd0);

        // Doubleword store then signed/unsigned byte loads of its top byte.
        set_op(1'b0, 1'b0, 1'b1, 1'b0, 4'b0011, 64'h10, 64'h0, 64'h8877665544332211);
        do_cycle();
        set_op(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 64'h17, 64'h0, 64'h0);
        do_cycle();
        check("lb_0x17", bus.mem_wb_readdata, 64'hFFFFFFFFFFFFFF88);
        set_op(1'b0, 1'b1, 1'b0, 1'b1, 4'b1100, 64'h17, 64'h0, 64'h0);
        do_cycle();
        check("lbu_0x17", bus.mem_wb_readdata, 64'h88);

        // Word store across the top of memory.
        set_op(1'b0, 1'b0, 1'b1, 1'b0, 4'b0010, 64'hFE, 64'h0, 64'hDEADBEEF);
        do_cycle();
        set_op(1'b0, 1'b1, 1'b0, 1'b1, 4'b0100, 64'h0, 64'h0, 64'h0);
        do_cycle();
`ifndef MEM_MISALIGN_CHECK_EN
        check("wrap_byte0", bus.mem_wb_readdata, 64'hAD);
        set_op(1'b0, 1'b1, 1'b0, 1'b1, 4'b0110, 64'hFE, 64'h0, 64'h0);
        do_cycle();
        check("lwu_wrap", bus.mem_wb_readdata, 64'hDEADBEEF);
`endif

        // Signed vs unsigned less-than with A=-1, B=1.
        set_op(1'b1, 1'b0, 1'b0, 1'b0, 4'b0100, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h1);
        #1;
        check("blt_taken", 64'(bus.pcsrc), 64'd1);
        do_cycle();
        set_op(1'b1, 1'b0, 1'b0, 1'b0, 4'b0110, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h1);
        #1;
        check("bltu_not_taken", 64'(bus.pcsrc), 64'd0);
        do_cycle();

        // Read-before-write on a simultaneous load/store.
        set_op(1'b0, 1'b0, 1'b1, 1'b0, 4'b0011, 64'h20, 64'h0, 64'h11);
        do_cycle();
        set_op(1'b0, 1'b1, 1'b1, 1'b1, 4'b0011, 64'h20, 64'h0, 64'h55);
        do_cycle();
        check("rbw_old", bus.mem_wb_readdata, 64'h11);
        set_op(1'b0, 1'b1, 1'b0, 1'b1, 4'b0011, 64'h20, 64'h0, 64'h0);
        do_cycle();
        check("rbw_new", bus.mem_wb_readdata, 64'h55);

`ifdef MEM_MISALIGN_CHECK_EN
        set_op(1'b0, 1'b1, 1'b0, 1'b1, 4'b0010, 64'h03, 64'h0, 64'h0);
        do_cycle();
        check("mis_flag", 64'(bus.misalign), 64'd1);
        check("mis_regwrite", 64'(bus.mem_wb_regwrite), 64'd0);
        set_op(1'b0, 1'b0, 1'b1, 1'b0, 4'b0010, 64'h02, 64'h0, 64'hCAFEF00D);
        do_cycle();
        set_op(1'b0, 1'b1, 1'b0, 1'b1, 4'b0011, 64'h00, 64'h0, 64'h0);
        do_cycle();
`endif

        // Randomized traffic with occasional mid-stream reset.
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 49) == 0);
            r = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0)
                r[7:0] = 8'($urandom_range(0, 31));
            else
                r[7:0] = 8'($urandom_range(240, 255));
            set_op(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   4'($urandom), r, {$urandom, $urandom}, {$urandom, $urandom});
            case ($urandom_range(0, 3))
                0: bus.ex_mem_writedata = bus.ex_mem_readdata1;
                1: bus.ex_mem_readdata1[63] = ~bus.ex_mem_writedata[63];
                default: ;
            endcase
            do_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
